// File: rtl/decode_issue_pkg.sv
// rtl/decode_issue_pkg.sv - shared opcode/funct constants and field positions
// Used by the decode/issue stage and the downstream ALU.
package decode_issue_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;

  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_SRL = 6'b000010;

  localparam int OP_HI  = 31;
  localparam int OP_LO  = 26;
  localparam int RS_HI  = 25;
  localparam int RS_LO  = 21;
  localparam int RT_HI  = 20;
  localparam int RT_LO  = 16;
  localparam int RD_HI  = 15;
  localparam int RD_LO  = 11;
  localparam int SH_HI  = 10;
  localparam int SH_LO  = 6;
  localparam int FN_HI  = 5;
  localparam int FN_LO  = 0;
  localparam int IMM_HI = 15;
  localparam int IMM_LO = 0;

  typedef enum logic [2:0] {
    K_RTYPE,
    K_LW,
    K_SW,
    K_BEQ,
    K_ILLEGAL
  } instr_kind_e;

  function automatic instr_kind_e classify(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      OP_RTYPE: begin
        if (fn == F_ADD || fn == F_SUB || fn == F_AND || fn == F_OR || fn == F_SRL)
          return K_RTYPE;
        return K_ILLEGAL;
      end
      OP_LW:   return K_LW;
      OP_SW:   return K_SW;
      OP_BEQ:  return K_BEQ;
      default: return K_ILLEGAL;
    endcase
  endfunction

endpackage

// File: rtl/decode_issue_if.sv
// rtl/decode_issue_if.sv - instruction, operand-bundle and writeback channels
// slave = decode stage view, master = driver/consumer view.
interface decode_issue_if #(
  parameter int DW        = 32,
  parameter int NREG_LOG2 = 5
);
  logic                 instr_valid;
  logic                 instr_ready;
  logic [31:0]          instr;
  logic                 out_valid;
  logic                 out_ready;
  logic [5:0]           opcode;
  logic [4:0]           shamt;
  logic [5:0]           funct;
  logic [DW-1:0]        in1;
  logic [DW-1:0]        in2;
  logic [DW-1:0]        st_data;
  logic [NREG_LOG2-1:0] dest;
  logic                 illegal;
  logic                 wb_en;
  logic [NREG_LOG2-1:0] wb_addr;
  logic [DW-1:0]        wb_data;

  modport slave (
    input  instr_valid, instr, out_ready, wb_en, wb_addr, wb_data,
    output instr_ready, out_valid, opcode, shamt, funct, in1, in2, st_data, dest, illegal
  );

  modport master (
    output instr_valid, instr, out_ready, wb_en, wb_addr, wb_data,
    input  instr_ready, out_valid, opcode, shamt, funct, in1, in2, st_data, dest, illegal
  );
endinterface

// File: rtl/decode_issue_regfile.sv
// rtl/decode_issue_regfile.sv - 2-read/1-write register file, r0 hardwired to zero
// Reads are combinational; the write lands on the clock edge.
module regfile_2r1w #(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] i_raddr_a,
  output logic [DW-1:0] o_rdata_a,
  input  logic [AW-1:0] i_raddr_b,
  output logic [DW-1:0] o_rdata_b,
  input  logic          i_wen,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata
);
  localparam int NREG = 1 << AW;

  logic [DW-1:0] r_mem [NREG];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) r_mem[i] <= '0;
    end else if (i_wen && i_waddr != '0) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata_a = (i_raddr_a == '0) ? '0 : r_mem[i_raddr_a];
  assign o_rdata_b = (i_raddr_b == '0) ? '0 : r_mem[i_raddr_b];
endmodule

// File: rtl/decode_issue.sv
// rtl/decode_issue.sv - decode/issue stage with scoreboard hazard stalls
// DECODE_ISSUE_WB_BYPASS_EN: forward same-cycle writeback into pending sources.
module decode_issue
  import decode_issue_pkg::*;
#(
  parameter int DW        = 32,
  parameter int NREG_LOG2 = 5
) (
  input logic           clk,
  input logic           rst_n,
  decode_issue_if.slave bus
);
  localparam int NREG = 1 << NREG_LOG2;

  logic [5:0]           w_op, w_funct;
  logic [4:0]           w_shamt;
  logic [NREG_LOG2-1:0] w_rs, w_rt, w_rd, w_dest;
  logic [15:0]          w_imm;
  instr_kind_e          w_kind;
  logic                 w_use_rs, w_use_rt, w_byp_rs, w_byp_rt;
  logic                 w_hazard, w_ready, w_accept;
  logic [DW-1:0]        w_rf_rs, w_rf_rt, w_rs_val, w_rt_val, w_imm_ext;
  logic [NREG-1:0]      w_set, w_clr;

  logic                 r_out_valid, r_illegal;
  logic [5:0]           r_opcode, r_funct;
  logic [4:0]           r_shamt;
  logic [DW-1:0]        r_in1, r_in2, r_st_data;
  logic [NREG_LOG2-1:0] r_dest;
  logic [NREG-1:0]      r_pend;

  assign w_op      = bus.instr[OP_HI:OP_LO];
  assign w_rs      = bus.instr[RS_HI:RS_LO];
  assign w_rt      = bus.instr[RT_HI:RT_LO];
  assign w_rd      = bus.instr[RD_HI:RD_LO];
  assign w_shamt   = bus.instr[SH_HI:SH_LO];
  assign w_funct   = bus.instr[FN_HI:FN_LO];
  assign w_imm     = bus.instr[IMM_HI:IMM_LO];
  assign w_imm_ext = {{(DW-16){w_imm[15]}}, w_imm};
  assign w_kind    = classify(w_op, w_funct);

  // SRL shifts rt only; rs is carried through but never checked for hazards.
  assign w_use_rs = (w_kind == K_RTYPE && w_funct != F_SRL) || w_kind == K_LW ||
                    w_kind == K_SW || w_kind == K_BEQ;
  assign w_use_rt = w_kind == K_RTYPE || w_kind == K_SW || w_kind == K_BEQ;
  assign w_dest   = (w_kind == K_RTYPE) ? w_rd : (w_kind == K_LW) ? w_rt : '0;

`ifdef DECODE_ISSUE_WB_BYPASS_EN
  assign w_byp_rs = bus.wb_en && bus.wb_addr == w_rs && w_rs != '0;
  assign w_byp_rt = bus.wb_en && bus.wb_addr == w_rt && w_rt != '0;
`else
  assign w_byp_rs = 1'b0;
  assign w_byp_rt = 1'b0;
`endif

  assign w_hazard = (w_use_rs && r_pend[w_rs] && !w_byp_rs) ||
                    (w_use_rt && r_pend[w_rt] && !w_byp_rt) ||
                    (w_dest != '0 && r_pend[w_dest]);
  assign w_ready  = (!r_out_valid || bus.out_ready) && !w_hazard;
  assign w_accept = bus.instr_valid && w_ready;

  regfile_2r1w #(.DW(DW), .AW(NREG_LOG2)) u_rf (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_raddr_a (w_rs),
    .o_rdata_a (w_rf_rs),
    .i_raddr_b (w_rt),
    .o_rdata_b (w_rf_rt),
    .i_wen     (bus.wb_en),
    .i_waddr   (bus.wb_addr),
    .i_wdata   (bus.wb_data)
  );

  assign w_rs_val = w_byp_rs ? bus.wb_data : w_rf_rs;
  assign w_rt_val = w_byp_rt ? bus.wb_data : w_rf_rt;

  // A same-cycle set for a new destination overrides the writeback clear.
  assign w_set = (w_accept && w_dest != '0) ? (NREG'(1) << w_dest) : '0;
  assign w_clr = bus.wb_en ? (NREG'(1) << bus.wb_addr) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_illegal   <= 1'b0;
      r_opcode    <= '0;
      r_shamt     <= '0;
      r_funct     <= '0;
      r_in1       <= '0;
      r_in2       <= '0;
      r_st_data   <= '0;
      r_dest      <= '0;
      r_pend      <= '0;
    end else begin
      r_pend <= ((r_pend & ~w_clr) | w_set) & ~NREG'(1);
      if (w_accept) begin
        r_out_valid <= 1'b1;
        r_illegal   <= (w_kind == K_ILLEGAL);
        r_opcode    <= w_op;
        r_shamt     <= w_shamt;
        r_funct     <= w_funct;
        r_dest      <= w_dest;
        r_in1       <= (w_kind == K_ILLEGAL) ? '0 : w_rs_val;
        r_in2       <= (w_kind == K_LW || w_kind == K_SW) ? w_imm_ext :
                       (w_kind == K_ILLEGAL) ? '0 : w_rt_val;
        r_st_data   <= (w_kind == K_SW) ? w_rt_val : '0;
      end else if (bus.out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign bus.instr_ready = w_ready;
  assign bus.out_valid   = r_out_valid;
  assign bus.illegal     = r_illegal;
  assign bus.opcode      = r_opcode;
  assign bus.shamt       = r_shamt;
  assign bus.funct       = r_funct;
  assign bus.in1         = r_in1;
  assign bus.in2         = r_in2;
  assign bus.st_data     = r_st_data;
  assign bus.dest        = r_dest;
endmodule
